// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, 16x oversampling with a 3-sample
// majority vote at each bit centre, valid/ready output with error pulses.
module uart_rx #(
    parameter int  CLK_FREQ  = 50000000,
    parameter int  BAUD_RATE = 9600,
    localparam int DIV       = CLK_FREQ / (BAUD_RATE * 16)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (DIV < 1) begin : g_div_illegal
        $fatal(1, "uart_rx: CLK_FREQ/(BAUD_RATE*16) must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t        state_r;
    logic          sync1_r, rxs_r, rxs_d_r;
    logic [CW-1:0] tick_cnt_r;
    logic [3:0]    sample_r;
    logic          vote7_r, vote8_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic [7:0]    rx_data_r;
    logic          rx_valid_r, frame_err_r, overrun_r, busy_r;
    logic          tick_s, start_s, decide_s, majority_s;

    // Only a falling edge starts a frame, so a held-low line cannot retrigger.
    assign start_s    = (state_r == ST_IDLE) && rxs_d_r && !rxs_r;
    assign tick_s     = (tick_cnt_r == TICK_MAX);
    assign decide_s   = tick_s && (sample_r == 4'd9);
    assign majority_s = (vote7_r & vote8_r) | (vote7_r & rxs_r) | (vote8_r & rxs_r);

    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign busy      = busy_r;

    // Input synchroniser, oversample tick generator, sample counter and vote capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r    <= 1'b1;
            rxs_r      <= 1'b1;
            rxs_d_r    <= 1'b1;
            tick_cnt_r <= CNT_ZERO;
            sample_r   <= 4'd0;
            vote7_r    <= 1'b0;
            vote8_r    <= 1'b0;
        end else begin
            sync1_r <= rx_in;
            rxs_r   <= sync1_r;
            rxs_d_r <= rxs_r;
            if (start_s || tick_s) begin
                tick_cnt_r <= CNT_ZERO;
            end else begin
                tick_cnt_r <= tick_cnt_r + CNT_ONE;
            end
            if (start_s) begin
                sample_r <= 4'd0;
            end else if (tick_s) begin
                sample_r <= sample_r + 4'd1;
            end
            if (tick_s && (sample_r == 4'd7)) begin
                vote7_r <= rxs_r;
            end
            if (tick_s && (sample_r == 4'd8)) begin
                vote8_r <= rxs_r;
            end
        end
    end

    // Frame state machine with the output stage and its valid/ready handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'd0;
            rx_data_r   <= 8'd0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    if (start_s) begin
                        state_r <= ST_START;
                        busy_r  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (decide_s) begin
                        if (majority_s) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r   <= ST_DATA;
                            bit_idx_r <= 3'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (decide_s) begin
                        shift_r[bit_idx_r] <= majority_s;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    // Leave on the decision tick so a following start edge is not missed.
                    if (decide_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        if (!majority_s) begin
                            frame_err_r <= 1'b1;
                        end else if (!rx_valid_r || rx_ready) begin
                            rx_data_r  <= shift_r;
                            rx_valid_r <= 1'b1;
                        end else begin
                            overrun_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at DIV=4 (64 cycles per bit): directed scenarios plus random
// frames, checked cycle by cycle against a frame-level model of the output port.
module tb_uart_rx;

    localparam int BIT_CYC   = 64;
    localparam int DELIV_OFS = 619;   // rx_in falls in cycle c0, byte visible at c0+619
    localparam int FRAME_CYC = 10 * BIT_CYC;

    logic       clk = 1'b0;
    logic       reset, rx_in, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    uart_rx #(.CLK_FREQ(64), .BAUD_RATE(1)) dut (
        .clk(clk), .reset(reset), .rx_in(rx_in), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Frame-level model: each sent frame yields one output event at a known cycle.
    typedef struct {
        int         due;
        logic [7:0] data;
        bit         good;
    } ev_t;

    ev_t        evq[$];
    ev_t        ev;
    bit         mon_en = 1'b0;
    bit         m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, xfer;
    logic [7:0] m_data = 8'd0;
    int         ovr_seen = 0, ferr_seen = 0;
    bit         rand_done;

    always @(negedge clk) begin
        if (mon_en) begin
            check_val("rx_valid", rx_valid, m_valid);
            if (m_valid) check_val("rx_data", rx_data, m_data);
            check_val("frame_err", frame_err, m_ferr);
            check_val("overrun", overrun, m_ovr);
            if (overrun) ovr_seen++;
            if (frame_err) ferr_seen++;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            xfer   = m_valid && rx_ready;
            if (reset) begin
                m_valid = 1'b0;
                m_data  = 8'd0;
                evq.delete();
            end else begin
                if (xfer) m_valid = 1'b0;
                if (evq.size() > 0 && evq[0].due == cyc + 1) begin
                    ev = evq.pop_front();
                    if (!ev.good) begin
                        m_ferr = 1'b1;
                    end else if (!m_valid) begin
                        m_valid = 1'b1;
                        m_data  = ev.data;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
            end
        end
    end

    // All stimulus tasks enter and leave 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input bit stop_val,
                              input bit spike, input int ready_at);
        int  c0, b, pos;
        logic lvl;
        c0 = cyc;
        evq.push_back('{c0 + DELIV_OFS, data, stop_val});
        for (int k = 0; k < FRAME_CYC; k++) begin
            b   = k / BIT_CYC;
            pos = k % BIT_CYC;
            if (b == 0) lvl = 1'b0;
            else if (b <= 8) lvl = data[b-1];
            else lvl = stop_val;
            if (spike && b >= 1 && b <= 8 && pos == 36) lvl = ~lvl;
            rx_in = lvl;
            if (ready_at >= 0 && k == ready_at) rx_ready = 1'b1;
            if (ready_at >= 0 && k == ready_at + 1) rx_ready = 1'b0;
            if (k == 4) check_val("busy_rise", busy, 1'b1);
            if (k == DELIV_OFS - 1) check_val("busy_hold", busy, 1'b1);
            if (k == DELIV_OFS) check_val("busy_fall", busy, 1'b0);
            idle(1);
        end
    endtask

    task automatic glitch(input int len);
        for (int k = 0; k < 60; k++) begin
            rx_in = (k < len) ? 1'b0 : 1'b1;
            if (k == 4) check_val("glitch_busy_rise", busy, 1'b1);
            if (k == 42) check_val("glitch_busy_hold", busy, 1'b1);
            if (k == 43) check_val("glitch_busy_fall", busy, 1'b0);
            idle(1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, rx_valid, 1'b0);
        check_val({tag, "_data"}, rx_data, 8'd0);
        check_val({tag, "_ferr"}, frame_err, 1'b0);
        check_val({tag, "_ovr"}, overrun, 1'b0);
        check_val({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, gap;
        reset    = 1'b1;
        rx_in    = 1'b1;
        rx_ready = 1'b0;
        idle(3);
        reset = 1'b0;
        check_all_zero("reset");
        mon_en = 1'b1;
        idle(20);

        // Single byte with the consumer always ready.
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        idle(10);

        // Back-to-back frames under backpressure.
        rx_ready = 1'b0;
        base = ovr_seen;
        send_frame(8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        idle(10);
        check_val("bp_ovr_count", ovr_seen - base, 2);
        check_val("bp_held_valid", rx_valid, 1'b1);
        check_val("bp_held_data", rx_data, 8'h00);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        idle(2);
        check_val("bp_drained", rx_valid, 1'b0);

        // Accept the pending byte on the very edge the next one is delivered.
        send_frame(8'h11, 1'b1, 1'b0, -1);
        idle(5);
        base = ovr_seen;
        send_frame(8'h22, 1'b1, 1'b0, DELIV_OFS - 1);
        idle(5);
        check_val("same_cycle_valid", rx_valid, 1'b1);
        check_val("same_cycle_data", rx_data, 8'h22);
        check_val("same_cycle_ovr", ovr_seen - base, 0);
        rx_ready = 1'b1;
        idle(2);
        rx_ready = 1'b0;

        // Framing error followed by a long break, then a clean frame.
        base = ferr_seen;
        send_frame(8'h55, 1'b0, 1'b0, -1);
        idle(40 * BIT_CYC);
        check_val("break_ferr_count", ferr_seen - base, 1);
        check_val("break_busy", busy, 1'b0);
        check_val("break_valid", rx_valid, 1'b0);
        rx_in = 1'b1;
        idle(100);
        rx_ready = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0, -1);
        idle(10);

        // False start from a short glitch, then noisy data bits.
        glitch(20);
        idle(100);
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        idle(10);

        // Reset mid-DATA while a byte is pending.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, -1);
        idle(5);
        check_val("pre_reset_valid", rx_valid, 1'b1);
        for (int k = 0; k < 200; k++) begin
            rx_in = (k < BIT_CYC) ? 1'b0 : 1'b1;
            idle(1);
        end
        check_val("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_all_zero("midreset");
        idle(800);
        rx_ready = 1'b1;
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        idle(10);

        // Random bytes, random gaps and a randomly toggling consumer.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    gap = $urandom_range(0, 80);
                    idle(gap);
                    send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, -1);
                end
                idle(10);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    rx_ready = 1'($urandom_range(0, 1));
                    idle(1);
                end
            end
        join
        rx_ready = 1'b1;
        idle(10);
        check_val("final_valid", rx_valid, 1'b0);
        check_val("events_left", evq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
